flag_cond_unit: RTL
===================

Name: flag_cond_unit

Overview:
- Consumer side of the ALU flag interface.
- Captures the 4-bit ALU flag vector {O,Z,S,C} into an architectural flags register.
- Resolves 16 conditional-branch codes against those flags, with a registered taken/valid result.
- Provides a small LIFO flag stack for PUSHF/POPF-style save and restore; sits between the ALU and the PC-select logic of the datapath.

Parameters:
- STACK_DEPTH, 4, number of flag-stack entries; power of two, at least 2.
- PTR_W, 2, log2(STACK_DEPTH); the stack count is PTR_W+1 bits wide.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flags_in  input  4  ALU flags, bit order [3]=O [2]=Z [1]=S [0]=C.
- flags_we  input  1  load flags_in into the flags register this cycle.
- branch_req  input  1  evaluate cond this cycle.
- cond  input  4  condition code, encoding given under Behaviour.
- branch_valid  output  1  registered; high for one cycle, one cycle after branch_req.
- branch_taken  output  1  registered; condition result, qualified by branch_valid.
- push  input  1  push the current flags register onto the stack.
- pop  input  1  pop the top of stack into the flags register.
- err_clr  input  1  clear stack_err.
- flags_out  output  4  current flags register.
- stack_full  output  1  count == STACK_DEPTH (combinational from count).
- stack_empty  output  1  count == 0 (combinational from count).
- stack_err  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (rst_n low at a clock edge):
  - flags_out=4'b0000, branch_valid=0, branch_taken=0, stack count=0, stack_err=0.
  - Stack contents are don't-care.
  - Reset overrides every other input in the same cycle, including an in-flight branch_req, whose result is dropped.
- Flags register update:
  - flags_we=1 loads flags_in.
  - Otherwise a successful pop loads the top entry.
  - Otherwise the register holds.
  - flags_we beats pop on the register; the pop still decrements the stack.
- Condition codes, where F is the evaluated flag vector:
  - 0 O; 1 !O; 2 Z; 3 !Z; 4 S; 5 !S.
  - 6 C; 7 !C; 8 C|Z; 9 !C&!Z.
  - 10 S^O; 11 !(S^O); 12 Z|(S^O); 13 !Z&!(S^O).
  - 14 always (1); 15 never (0).
- Branch latency:
  - branch_req in cycle N gives branch_valid=1 with branch_taken in cycle N+1.
  - With no request, branch_valid=0 and branch_taken=0 the next cycle.
  - Back-to-back requests each produce their own result, one per cycle.
- Stack operations:
  - Push writes the pre-update flags register to entry[count] and increments count.
  - Pop reads entry[count-1] and decrements count.
  - Push while full: stack unchanged, stack_err set.
  - Pop while empty: stack and flags register unchanged, stack_err set.
  - push and pop in the same cycle: stack no-op, no error, flags register unchanged by the stack.
  - push with flags_we in the same cycle: the old flags are pushed, then the register loads flags_in.
- stack_err:
  - Set by an overflow or underflow event.
  - Cleared by err_clr; if a set event and err_clr occur together, set wins.
- No wrap-around: count saturates within 0..STACK_DEPTH.

Optional Feature:
- Macro: FLAG_COND_BYPASS_EN.
- Defined: when branch_req and flags_we are high in the same cycle, F = flags_in (forwarded). This gives compare-and-branch in back-to-back cycles without a stall.
- Undefined: F is always the registered flags_out. A same-cycle flags_we is not visible to that branch.
- Pop-to-register data is never forwarded in either build.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> flags_out=0, stack_empty=1, stack_err=0, branch_valid=0.
- Write then branch: flags_we with flags_in=4'b1010 (O=1,S=1); next cycle branch_req with cond=10, then cond=11, then cond=0 -> branch_taken=0, 1, 1 on three consecutive valid cycles.
- Bypass path: flags_in=4'b0100 with flags_we=1 and branch_req=1 (cond=2) in the same cycle, previous flags 0 -> branch_taken=1 with FLAG_COND_BYPASS_EN defined, 0 without it.
- Stack fill/overflow with STACK_DEPTH=4: push values 1, 2, 3, 4, then push again -> stack_full=1, stack_err=1. Then four pops -> flags_out = 4, 3, 2, 1, ending with stack_empty=1.
- Underflow: pop on an empty stack with flags_out=4'b0011 -> flags_out stays 3, stack_err=1. err_clr -> stack_err=0.
- Simultaneous and reset: push+pop at count=2 -> count stays 2, no error. branch_req followed by rst_n=0 in the next cycle -> branch_valid=0.

Source files
------------

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: architectural {O,Z,S,C} flags register, 16-way branch-condition resolver, LIFO flag stack.
// Latency: flags/stack update on the clock edge; branch result registered, valid one cycle after branch_req.
// Backpressure: none -- every request is accepted each cycle; stack misuse raises sticky stack_err instead.
// Optional build macro FLAG_COND_BYPASS_EN: forwards a same-cycle flags_in write to the branch evaluation.
module flag_cond_unit #(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] flags_in,
  input  logic       flags_we,
  input  logic       branch_req,
  input  logic [3:0] cond,
  output logic       branch_valid,
  output logic       branch_taken,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  output logic [3:0] flags_out,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(STACK_DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  logic [3:0]       flags_q;
  logic [PTR_W:0]   count;
  logic [3:0]       stack_mem [STACK_DEPTH];
  logic [3:0]       eval_flags;
  logic             push_only;
  logic             pop_only;
  logic             push_ok;
  logic             pop_ok;
  logic             stack_evt;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  // Resolve a condition code against a flag vector ordered {O,Z,S,C}.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic o, z, s, cy, lt;
    o  = f[3];
    z  = f[2];
    s  = f[1];
    cy = f[0];
    lt = s ^ o;
    case (c)
      4'd0:    cond_eval = o;
      4'd1:    cond_eval = !o;
      4'd2:    cond_eval = z;
      4'd3:    cond_eval = !z;
      4'd4:    cond_eval = s;
      4'd5:    cond_eval = !s;
      4'd6:    cond_eval = cy;
      4'd7:    cond_eval = !cy;
      4'd8:    cond_eval = cy | z;
      4'd9:    cond_eval = !cy & !z;
      4'd10:   cond_eval = lt;
      4'd11:   cond_eval = !lt;
      4'd12:   cond_eval = z | lt;
      4'd13:   cond_eval = !z & !lt;
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign flags_out   = flags_q;
  assign stack_full  = (count == DEPTH_C);
  assign stack_empty = (count == '0);

  // Simultaneous push and pop cancel out, so only a lone push or pop touches the stack.
  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign push_ok   = push_only & ~stack_full;
  assign pop_ok    = pop_only & ~stack_empty;
  assign stack_evt = (push_only & stack_full) | (pop_only & stack_empty);
  assign wr_idx    = count[PTR_W-1:0];
  assign rd_idx    = PTR_W'(count - ONE_C);

  // Select the flag vector the branch condition sees; popped data is never forwarded.
  always_comb begin
    eval_flags = flags_q;
`ifdef FLAG_COND_BYPASS_EN
    if (flags_we) begin
      eval_flags = flags_in;
    end
`endif
  end

  // Flags register: ALU write has priority over a pop restore.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end else if (pop_ok) begin
      flags_q <= stack_mem[rd_idx];
    end
  end

  // Stack occupancy count, saturating within 0..STACK_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push_ok) begin
      count <= count + ONE_C;
    end else if (pop_ok) begin
      count <= count - ONE_C;
    end
  end

  // Stack storage holds the pre-update flags on push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_idx] <= flags_q;
    end
  end

  // Sticky overflow/underflow flag; a new event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stack_err <= 1'b0;
    end else if (stack_evt) begin
      stack_err <= 1'b1;
    end else if (err_clr) begin
      stack_err <= 1'b0;
    end
  end

  // Registered branch result, one cycle after the request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      branch_valid <= branch_req;
      branch_taken <= branch_req & cond_eval(cond, eval_flags);
    end
  end

endmodule
